upsample_mcu_rasterizer: RTL and testbench
==========================================

UPSAMPLE_MCU_RASTERIZER -- requirements
Module: upsample_mcu_rasterizer

Interface
REQ-001 Parameters: none; all sizes come from the shared package.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ch  input  $clog2(`CH+1)  channel tag of the incoming MCU.
REQ-005 valid_in  input  4  per-quadrant valid from the 4x4 bilinear supersampler; bit3=top-left, bit2=top-right, bit1=bottom-left, bit0=bottom-right.
REQ-006 block_1_in..block_4_in  input  8 each, [7:0][7:0]  upsampled 8x8 quadrants; 1=bottom-right, 2=bottom-left, 3=top-right, 4=top-left.
REQ-007 in_ready  output  1  block can capture an MCU this cycle.
REQ-008 row_out  output  8 each, [15:0]  one 16-pixel raster row of the 16x16 MCU; index 0 = leftmost.
REQ-009 row_idx  output  4  raster row number of row_out, 0..15.
REQ-010 ch_out  output  $clog2(`CH+1)  channel tag of the MCU being emitted.
REQ-011 valid_out  output  1  row_out, row_idx, ch_out and last_out are valid.
REQ-012 ready_in  input  1  downstream accepts the current row.
REQ-013 last_out  output  1  high with valid_out when row_idx==15.
REQ-014 err_partial  output  1  one-cycle pulse when a partial quadrant set is dropped.

Function
REQ-015 States SHALL be IDLE and EMIT.
REQ-016 Capture SHALL occur when valid_in==4'hF and in_ready=1: latch all four quadrants plus ch; next state EMIT; row_idx=0.
REQ-017 in_ready SHALL be combinational: 1 in IDLE; in EMIT, 1 only when valid_out && ready_in && row_idx==15.
REQ-018 A row beat SHALL complete when valid_out && ready_in; row_idx then increments by 1.
REQ-019 Row r<8: row_out[0..7]=block_4 row r, row_out[8..15]=block_3 row r; row r>=8: row_out[0..7]=block_2 row r-8, row_out[8..15]=block_1 row r-8.
REQ-020 valid_out SHALL be 1 for the whole of EMIT and 0 in IDLE; first valid_out is the cycle after capture (latency 1).
REQ-021 While valid_out && !ready_in, row_out, row_idx, ch_out and last_out SHALL hold stable.
REQ-022 On the final beat (row 15 accepted): a simultaneous capture restarts EMIT at row 0 with the new data and no bubble; otherwise go to IDLE.
REQ-023 Full-MCU throughput SHALL be 16 cycles per MCU under continuous ready_in.
REQ-024 valid_in neither 4'h0 nor 4'hF while in_ready=1 SHALL drop the data and pulse err_partial for 1 cycle; state is unchanged.
REQ-025 valid_in with in_ready=0 SHALL be ignored, with no error pulse; upstream is responsible for holding.
REQ-026 row_idx SHALL NOT wrap except via REQ-022.

Reset
REQ-027 Reset asserted SHALL force IDLE asynchronously, with valid_out=0, last_out=0, err_partial=0, row_idx=0, ch_out=0, and the buffer and row_out all zero.
REQ-028 Reset mid-EMIT SHALL discard the buffered MCU; in_ready=1 on the first cycle after deassertion.

Structure
REQ-029 The shared package (sys_defs) SHALL hold: MCU_DIM=16, BLK_DIM=8, pixel typedef (8 bits), and the rasterizer state enum typedef.
REQ-030 There SHALL be one sub-module, mcu_row_select: a combinational quadrant-to-row mux implementing REQ-019; the FSM, buffer and counter stay in the top module.

Verification
REQ-031 Reset, then an MCU with pixel = quadrant*64 + row*8 + col and ready_in=1 -> 16 consecutive beats; row 0 = {block_4 row0, block_3 row0}, row 9 = {block_2 row1, block_1 row1}; last_out only at row 15.
REQ-032 Stall: drop ready_in for 3 cycles at row 5 -> row 5 data held constant for 4 cycles, then row 6; total of 16 accepted beats.
REQ-033 Back-to-back: a second MCU (ch=2) presented during row 15 with ready_in=1 -> row 0 of the new MCU, ch_out=2, on the next cycle with no IDLE cycle.
REQ-034 valid_in=4'b0111 in IDLE -> err_partial pulses once, valid_out stays 0, and a following 4'hF captures normally.
REQ-035 Reset asserted at row 7 -> valid_out=0 immediately, in_ready=1 after deassertion, and a new MCU emits from row 0.

Source files
------------

// File: rtl/upsample_mcu_rasterizer_pkg.sv
// upsample_mcu_rasterizer_pkg: shared sizes, pixel/block/row types and rasterizer state
`ifndef CH
`define CH 3
`endif
package sys_defs;
  localparam int MCU_DIM = 16;
  localparam int BLK_DIM = 8;
  localparam int CH_W = $clog2(`CH + 1);
  typedef logic [7:0] pixel_t;
  typedef pixel_t [BLK_DIM-1:0][BLK_DIM-1:0] block_t;
  typedef pixel_t [MCU_DIM-1:0] row_t;
  typedef enum logic {IDLE, EMIT} rast_state_t;
endpackage

// File: rtl/upsample_mcu_rasterizer_if.sv
// upsample_mcu_rasterizer_if: quadrant capture side and raster row emit side of the rasterizer
interface upsample_mcu_rasterizer_if;
  import sys_defs::*;
  logic [CH_W-1:0] ch;
  logic [3:0] valid_in;
  block_t block_1_in;
  block_t block_2_in;
  block_t block_3_in;
  block_t block_4_in;
  logic in_ready;
  row_t row_out;
  logic [3:0] row_idx;
  logic [CH_W-1:0] ch_out;
  logic valid_out;
  logic ready_in;
  logic last_out;
  logic err_partial;
  modport master (
    output ch, valid_in, block_1_in, block_2_in, block_3_in, block_4_in, ready_in,
    input in_ready, row_out, row_idx, ch_out, valid_out, last_out, err_partial
  );
  modport slave (
    input ch, valid_in, block_1_in, block_2_in, block_3_in, block_4_in, ready_in,
    output in_ready, row_out, row_idx, ch_out, valid_out, last_out, err_partial
  );
endinterface

// File: rtl/upsample_mcu_rasterizer_row_select.sv
// mcu_row_select: picks the two quadrants covering raster row r and concatenates their rows
module mcu_row_select
  import sys_defs::*;
(
  input  block_t     b1,
  input  block_t     b2,
  input  block_t     b3,
  input  block_t     b4,
  input  logic [3:0] row,
  output row_t       row_out
);
  // upper half rows come from blocks 4|3, lower half from blocks 2|1
  always_comb begin
    row_out = '0;
    for (int c = 0; c < BLK_DIM; c++) begin
      row_out[c] = row[3] ? b2[row[2:0]][c] : b4[row[2:0]][c];
      row_out[c+BLK_DIM] = row[3] ? b1[row[2:0]][c] : b3[row[2:0]][c];
    end
  end
endmodule

// File: rtl/upsample_mcu_rasterizer.sv
// upsample_mcu_rasterizer: buffers a 16x16 MCU from four 8x8 quadrants and streams it as 16 raster rows
module upsample_mcu_rasterizer
  import sys_defs::*;
(
  input logic clock,
  input logic reset,
  upsample_mcu_rasterizer_if.slave bus
);
  rast_state_t state, state_n;
  block_t b1, b2, b3, b4;
  logic [CH_W-1:0] ch_q;
  logic [3:0] idx;
  logic err_q, beat, last, cap, part, vout, rdy;
  // handshake decode and next state; a final beat with a full capture re-enters EMIT without a bubble
  always_comb begin
    vout = state == EMIT;
    last = idx == 4'd15;
    beat = vout & bus.ready_in;
    rdy = (state == IDLE) | (beat & last);
    cap = rdy & (bus.valid_in == 4'hF);
    part = rdy & (bus.valid_in != 4'h0) & (bus.valid_in != 4'hF);
    state_n = cap ? EMIT : (beat & last) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // MCU buffer, row counter and partial-drop pulse; counter holds at 15 when returning to IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      b1 <= '0;
      b2 <= '0;
      b3 <= '0;
      b4 <= '0;
      ch_q <= '0;
      idx <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= part;
      if (cap) begin
        b1 <= bus.block_1_in;
        b2 <= bus.block_2_in;
        b3 <= bus.block_3_in;
        b4 <= bus.block_4_in;
        ch_q <= bus.ch;
        idx <= 4'd0;
      end else if (beat & ~last) idx <= idx + 4'd1;
    end
  end
  assign bus.in_ready = rdy;
  assign bus.valid_out = vout;
  assign bus.last_out = vout & last;
  assign bus.row_idx = idx;
  assign bus.ch_out = ch_q;
  assign bus.err_partial = err_q;
  mcu_row_select u_sel (.b1(b1), .b2(b2), .b3(b3), .b4(b4), .row(idx), .row_out(bus.row_out));
endmodule

// File: tb/tb_upsample_mcu_rasterizer.sv
// tb_upsample_mcu_rasterizer: directed/randomized checks of the MCU rasterizer against a pixel-grid model
module tb_upsample_mcu_rasterizer;
  import sys_defs::*;
  logic clk = 1'b0;
  logic reset;
  int total = 0, passed = 0, fails = 0;
  pixel_t cur[4][8][8];
  pixel_t nxt[4][8][8];
  int cur_ch, nxt_ch;
  upsample_mcu_rasterizer_if bus ();
  upsample_mcu_rasterizer dut (.clock(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic row_t exp_row(input int r);
    row_t e;
    for (int c = 0; c < 16; c++) e[c] = cur[(r < 8 ? 2 : 0) + (c < 8 ? 1 : 0)][r % 8][c % 8];
    return e;
  endfunction

  task automatic present(input int nch, input bit rnd);
    for (int q = 0; q < 4; q++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          nxt[q][r][c] = rnd ? 8'($urandom) : 8'((q + 1) * 64 + r * 8 + c);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        bus.block_1_in[r][c] = nxt[0][r][c];
        bus.block_2_in[r][c] = nxt[1][r][c];
        bus.block_3_in[r][c] = nxt[2][r][c];
        bus.block_4_in[r][c] = nxt[3][r][c];
      end
    nxt_ch = nch;
    bus.ch = CH_W'(nch);
    bus.valid_in = 4'hF;
  endtask

  task automatic start(input int nch, input bit rnd);
    @(negedge clk);
    check("idle_valid_out", bus.valid_out, 0);
    check("idle_in_ready", bus.in_ready, 1);
    present(nch, rnd);
    bus.ready_in = 1'b1;
    cur = nxt;
    cur_ch = nxt_ch;
  endtask

  task automatic drain(input int stall_at, input int stall_n, input bit chain, input int nch, input int rst_at);
    int r = 0, n = 0, held = 0;
    while (r < 16 && n < 200) begin
      @(negedge clk);
      n++;
      check("valid_out", bus.valid_out, 1);
      check("row_idx", bus.row_idx, r);
      check("row_out", bus.row_out, exp_row(r));
      check("ch_out", bus.ch_out, cur_ch);
      check("last_out", bus.last_out, r == 15);
      check("err_quiet", bus.err_partial, 0);
      if (r == rst_at) begin
        reset = 1'b1;
        bus.valid_in = 4'h0;
        #1;
        check("rst_valid_out", bus.valid_out, 0);
        check("rst_last_out", bus.last_out, 0);
        check("rst_row_idx", bus.row_idx, 0);
        check("rst_row_out", bus.row_out, 0);
        check("rst_ch_out", bus.ch_out, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_valid_out", bus.valid_out, 0);
        return;
      end
      bus.valid_in = r < 15 ? 4'($urandom) : 4'h0;
      if (r == stall_at && held < stall_n) begin
        bus.ready_in = 1'b0;
        held++;
      end else bus.ready_in = 1'b1;
      if (r == 15 && chain && bus.ready_in) present(nch, 1'b1);
      #1;
      check("in_ready", bus.in_ready, r == 15 && bus.ready_in);
      if (bus.ready_in) r++;
    end
    check("beats", r, 16);
    if (chain) begin
      cur = nxt;
      cur_ch = nxt_ch;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.ch = '0;
    bus.valid_in = 4'h0;
    bus.block_1_in = '0;
    bus.block_2_in = '0;
    bus.block_3_in = '0;
    bus.block_4_in = '0;
    bus.ready_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_valid_out", bus.valid_out, 0);
    check("reset_last_out", bus.last_out, 0);
    check("reset_err", bus.err_partial, 0);
    check("reset_row_idx", bus.row_idx, 0);
    check("reset_ch_out", bus.ch_out, 0);
    check("reset_row_out", bus.row_out, 0);
    check("reset_in_ready", bus.in_ready, 1);
    reset = 1'b0;
    start(1, 1'b0);
    drain(-1, 0, 1'b0, 0, -1);
    start(1, 1'b1);
    drain(5, 3, 1'b1, 2, -1);
    drain(-1, 0, 1'b0, 0, -1);
    @(negedge clk);
    check("idle_after_b2b", bus.valid_out, 0);
    bus.valid_in = 4'b0111;
    #1;
    check("partial_in_ready", bus.in_ready, 1);
    @(negedge clk);
    check("partial_err", bus.err_partial, 1);
    check("partial_valid_out", bus.valid_out, 0);
    bus.valid_in = 4'h0;
    @(negedge clk);
    check("partial_err_once", bus.err_partial, 0);
    check("partial_still_idle", bus.valid_out, 0);
    start(3, 1'b1);
    drain(-1, 0, 1'b0, 0, -1);
    start(2, 1'b1);
    drain(-1, 0, 1'b0, 0, 7);
    start(int'($urandom_range(0, 3)), 1'b1);
    drain(int'($urandom_range(0, 15)), int'($urandom_range(1, 4)), 1'b0, 0, -1);
    @(negedge clk);
    check("final_idle", bus.valid_out, 0);
    check("final_in_ready", bus.in_ready, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
